// File: rtl/wave_sequencer.sv
// Sequences one systolic-array op: weight load, feature stream, skew flush, done.
// Latency: start -> done = 2*ksize + msize + nsize cycles (1 cycle on a zero-size request).
// Backpressure: none; start is taken only while ready=1, otherwise dropped. Optional counter: WAVE_SEQ_PERF_EN.
module wave_sequencer #(
    parameter int DIM_W = 5,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] ksize,
    input  logic [DIM_W-1:0] nsize,
    input  logic [DIM_W-1:0] msize,
    input  logic [1:0]       mode,
    input  logic             if_mux_sel,
    input  logic             w_mux_sel,
    output logic             ready,
    output logic             busy,
    output logic [1:0]       mode_q,
    output logic             if_mux_sel_q,
    output logic             w_mux_sel_q,
    output logic             w_load,
    output logic [DIM_W-1:0] w_addr,
    output logic             if_valid,
    output logic [DIM_W-1:0] if_addr,
    output logic             done,
    output logic             err
`ifdef WAVE_SEQ_PERF_EN
    ,
    input  logic             perf_clr,
    output logic [15:0]      busy_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [DIM_W-1:0] k_q, n_q, m_q;
    logic [DIM_W-1:0] w_addr_n, if_addr_n;
    logic             accept, zero_req, err_n;
    logic [CNT_W-1:0] last_k, last_m, last_f;

    assign accept   = (state == S_IDLE) && start;
    assign zero_req = (ksize == '0) || (nsize == '0) || (msize == '0);

    // Terminal counts; only consulted in phases where the latched sizes are nonzero.
    assign last_k = CNT_W'(k_q) - CNT_W'(1);
    assign last_m = CNT_W'(m_q) - CNT_W'(1);
    assign last_f = CNT_W'(k_q) + CNT_W'(n_q) - CNT_W'(2);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        err_n   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (start) begin
                    state_n = zero_req ? S_DONE : S_LOAD_W;
                    err_n   = zero_req;
                end
            end
            S_LOAD_W: begin
                if (cnt == last_k) begin
                    state_n = S_STREAM;
                    cnt_n   = '0;
                end
            end
            S_STREAM: begin
                if (cnt == last_m) begin
                    state_n = S_FLUSH;
                    cnt_n   = '0;
                end
            end
            S_FLUSH: begin
                if (cnt == last_f) begin
                    state_n = S_DONE;
                    cnt_n   = '0;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the phase they describe.
    assign w_addr_n  = (state_n == S_LOAD_W) ? cnt_n[DIM_W-1:0] : w_addr;
    assign if_addr_n = (state_n == S_STREAM) ? cnt_n[DIM_W-1:0] : if_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            k_q          <= '0;
            n_q          <= '0;
            m_q          <= '0;
            mode_q       <= '0;
            if_mux_sel_q <= 1'b0;
            w_mux_sel_q  <= 1'b0;
            ready        <= 1'b1;
            busy         <= 1'b0;
            w_load       <= 1'b0;
            w_addr       <= '0;
            if_valid     <= 1'b0;
            if_addr      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ready    <= (state_n == S_IDLE);
            busy     <= (state_n != S_IDLE);
            w_load   <= (state_n == S_LOAD_W);
            w_addr   <= w_addr_n;
            if_valid <= (state_n == S_STREAM);
            if_addr  <= if_addr_n;
            done     <= (state_n == S_DONE);
            err      <= err_n;
            if (accept) begin
                k_q          <= ksize;
                n_q          <= nsize;
                m_q          <= msize;
                mode_q       <= mode;
                if_mux_sel_q <= if_mux_sel;
                w_mux_sel_q  <= w_mux_sel;
            end
        end
    end

`ifdef WAVE_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || perf_clr) begin
            busy_cycles <= '0;
        end else if (busy && (busy_cycles != 16'hFFFF)) begin
            busy_cycles <= busy_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wave_sequencer.sv
// Randomized scoreboard bench for wave_sequencer: the driver predicts beats and done
// from operation sizes, an independent negedge monitor pops and compares.
module tb_wave_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] ksize = '0, nsize = '0, msize = '0;
    logic [1:0] mode = '0;
    logic       if_mux_sel = 1'b0, w_mux_sel = 1'b0;
    logic       ready, busy, if_mux_sel_q, w_mux_sel_q, w_load, if_valid, done, err;
    logic [1:0] mode_q;
    logic [4:0] w_addr, if_addr;
`ifdef WAVE_SEQ_PERF_EN
    logic        perf_clr = 1'b0;
    logic [15:0] busy_cycles;
`endif

    wave_sequencer #(.DIM_W(5), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .start(start),
        .ksize(ksize), .nsize(nsize), .msize(msize),
        .mode(mode), .if_mux_sel(if_mux_sel), .w_mux_sel(w_mux_sel),
        .ready(ready), .busy(busy), .mode_q(mode_q),
        .if_mux_sel_q(if_mux_sel_q), .w_mux_sel_q(w_mux_sel_q),
        .w_load(w_load), .w_addr(w_addr), .if_valid(if_valid), .if_addr(if_addr),
        .done(done), .err(err)
`ifdef WAVE_SEQ_PERF_EN
        , .perf_clr(perf_clr), .busy_cycles(busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    logic rst_d = 1'b1;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    typedef struct { int addr; int due; } beat_t;
    typedef struct { bit err; int due; } done_t;
    beat_t w_q[$];
    beat_t if_q[$];
    done_t d_q[$];

    int checks = 0, errors = 0;
    int idle_from = 0, acc_c = -1;
    logic [1:0] exp_mode = '0;
    logic       exp_ifs = 1'b0, exp_ws = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the predicted queues.
    always @(negedge clk) begin
        beat_t b;
        done_t d;
        bit    exp_rdy;
        int    last_w, last_if;
        if (rst_d) begin
            chk("rst_ready", ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_w_load", w_load, 0);
            chk("rst_if_valid", if_valid, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
            chk("rst_mode_q", mode_q, 0);
            chk("rst_w_addr", w_addr, 0);
            chk("rst_if_addr", if_addr, 0);
            last_w  = 0;
            last_if = 0;
        end else begin
            exp_rdy = !(acc_c >= 0 && cyc > acc_c && cyc < idle_from);
            chk("ready", ready, exp_rdy);
            chk("busy", busy, !exp_rdy);
            if (acc_c >= 0 && cyc > acc_c) begin
                chk("mode_q", mode_q, exp_mode);
                chk("if_mux_sel_q", if_mux_sel_q, exp_ifs);
                chk("w_mux_sel_q", w_mux_sel_q, exp_ws);
            end
            if (w_load) begin
                if (w_q.size() == 0) chk("w_load_unexpected", 1, 0);
                else begin
                    b = w_q.pop_front();
                    chk("w_addr", w_addr, b.addr);
                    chk("w_load_cycle", cyc, b.due);
                end
                last_w = w_addr;
            end else chk("w_addr_hold", w_addr, last_w);
            if (if_valid) begin
                if (if_q.size() == 0) chk("if_valid_unexpected", 1, 0);
                else begin
                    b = if_q.pop_front();
                    chk("if_addr", if_addr, b.addr);
                    chk("if_valid_cycle", cyc, b.due);
                end
                last_if = if_addr;
            end else chk("if_addr_hold", if_addr, last_if);
            if (w_load && if_valid) chk("w_load_and_if_valid", 1, 0);
            if (done) begin
                if (d_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d = d_q.pop_front();
                    chk("err", err, d.err);
                    chk("done_cycle", cyc, d.due);
                end
            end else if (err) chk("err_without_done", 1, 0);
            if (w_q.size() > 0 && cyc > w_q[0].due) begin
                chk("w_beat_timeout", cyc, w_q[0].due);
                void'(w_q.pop_front());
            end
            if (if_q.size() > 0 && cyc > if_q[0].due) begin
                chk("if_beat_timeout", cyc, if_q[0].due);
                void'(if_q.pop_front());
            end
            if (d_q.size() > 0 && cyc > d_q[0].due) begin
                chk("done_timeout", cyc, d_q[0].due);
                void'(d_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one start pulse; the reference model decides acceptance from its own busy window.
    task automatic issue(input int k, input int n, input int m, input int mo, input bit i, input bit w);
        int L;
        ksize = 5'(k); nsize = 5'(n); msize = 5'(m);
        mode = 2'(mo); if_mux_sel = i; w_mux_sel = w;
        start = 1'b1;
        if (cyc >= idle_from) begin
            if (k == 0 || n == 0 || m == 0) L = 1;
            else begin
                L = k + m + (k + n - 1) + 1;
                for (int j = 0; j < k; j++) w_q.push_back('{j, cyc + 1 + j});
                for (int j = 0; j < m; j++) if_q.push_back('{j, cyc + 1 + k + j});
            end
            d_q.push_back('{(L == 1), cyc + L});
            exp_mode  = 2'(mo);
            exp_ifs   = i;
            exp_ws    = w;
            acc_c     = cyc;
            idle_from = cyc + L + 1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        while (cyc < idle_from) tick();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) tick();

        issue(3, 2, 4, 2, 1, 0);
        wait_idle();
        repeat (2) tick();
        issue(5, 3, 0, 1, 0, 1);
        wait_idle();
        issue(31, 31, 31, 3, 1, 1);
        wait_idle();

        issue(4, 2, 3, 1, 0, 1);
        repeat (2) tick();
        issue(7, 7, 7, 2, 1, 0);
        wait_idle();
        issue(1, 2, 1, 0, 1, 1);
        wait_idle();

        issue(3, 5, 10, 2, 1, 0);
        repeat (5) tick();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        w_q.delete(); if_q.delete(); d_q.delete();
        idle_from = 0;
        acc_c     = -1;
        repeat (30) tick();

        for (int t = 0; t < 40; t++) begin
            int k, n, m;
            k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
            n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
            m = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
            issue(k, n, m, $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 40)) tick();
        end
        wait_idle();

`ifdef WAVE_SEQ_PERF_EN
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        issue(1, 1, 1, 1, 0, 0);
        wait_idle();
        issue(1, 1, 1, 2, 1, 1);
        wait_idle();
        repeat (2) tick();
        chk("busy_cycles", busy_cycles, 8);
        perf_clr = 1'b1;
        tick();
        chk("busy_cycles_clr", busy_cycles, 0);
        perf_clr = 1'b0;
`endif

        repeat (3) tick();
        chk("w_q_empty", w_q.size(), 0);
        chk("if_q_empty", if_q.size(), 0);
        chk("d_q_empty", d_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Downstream of the mode decoder. Consumes its mode, if_mux_sel and w_mux_sel outputs together with the GEMM dimensions.
- Sequences one systolic-array operation through four phases: weight load, input-feature stream, pipeline flush, done.
- Latches the decoder outputs at start and holds them stable, so array routing cannot change mid-operation.
- Drives read addresses and enables for the weight and input-feature buffers.

Parameters:
- DIM_W, 5, width of ksize/nsize/msize and of both read addresses.
- CNT_W, 7, phase counter width; must satisfy 2^CNT_W > 2*(2^DIM_W - 1).

Ports:
- clk  input  1  system clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; accepted only when ready=1
- ksize  input  DIM_W  reduction dimension (weight rows)
- nsize  input  DIM_W  output columns
- msize  input  DIM_W  input-feature rows to stream
- mode  input  2  array mode from decoder (00/01/10/11)
- if_mux_sel  input  1  input-feature routing select from decoder
- w_mux_sel  input  1  weight routing select from decoder
- ready  output  1  high only in IDLE
- busy  output  1  high in every non-IDLE state
- mode_q  output  2  mode latched at start
- if_mux_sel_q  output  1  latched if_mux_sel
- w_mux_sel_q  output  1  latched w_mux_sel
- w_load  output  1  weight-buffer read enable / array weight shift
- w_addr  output  DIM_W  weight-buffer row address
- if_valid  output  1  input-feature read enable / array data valid
- if_addr  output  DIM_W  input-feature row address
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, on a zero-size request

Behaviour:
- States: IDLE, LOAD_W, STREAM, FLUSH, DONE. All outputs are registered.
- Reset values: state=IDLE, ready=1, busy=0, all other outputs 0.
- Reset mid-operation returns to IDLE on the next edge and drops any operation in flight. No done is issued for it.
- IDLE:
  - start=1 latches ksize, nsize, msize, mode, if_mux_sel and w_mux_sel.
  - If any size is 0, go to DONE with err=1.
  - Otherwise go to LOAD_W with the counter cleared.
  - start while busy is ignored: no queueing, no error.
- LOAD_W: lasts ksize cycles.
  - w_load=1.
  - w_addr = 0..ksize-1, incrementing by one per cycle.
  - On the last cycle (cnt=ksize-1), go to STREAM.
- STREAM: lasts msize cycles.
  - if_valid=1, w_load=0.
  - if_addr = 0..msize-1.
  - On the last cycle, go to FLUSH.
- FLUSH: lasts ksize+nsize-1 cycles.
  - if_valid=0, w_load=0.
  - The array drains its skew.
  - The count is computed at CNT_W bits; there is no overflow at max sizes (31+31-1=61).
- DONE: lasts 1 cycle.
  - done=1. err=1 only if entered on a zero-size request.
  - Then go to IDLE.
  - ready rises the cycle after DONE, so start can be re-accepted in that cycle.
- Addresses hold their last value outside their active phase. They clear to 0 on entry to LOAD_W and STREAM respectively.
- The *_q outputs update only on an accepted start; they hold through DONE and IDLE.
- Latency from an accepted start to done: ksize + msize + (ksize+nsize-1) + 1 cycles.

Optional Feature:
- Macro: WAVE_SEQ_PERF_EN.
- When defined:
  - Adds output busy_cycles [15:0] and input perf_clr [0:0].
  - busy_cycles increments every cycle busy=1 and saturates at 16'hFFFF.
  - busy_cycles clears on rst or perf_clr; perf_clr has priority over increment.
- When undefined: neither port exists and there is no counter logic. All other behaviour is identical.

Test Plan:
- Reset: hold rst for 3 cycles mid-STREAM -> next cycle state=IDLE, ready=1, busy=0, if_valid=0, done=0. No done pulse afterwards.
- Nominal: ksize=3, nsize=2, msize=4, mode=10 -> w_load for 3 cycles (w_addr 0,1,2), then if_valid for 4 cycles (if_addr 0..3), then 4 idle flush cycles. done is high in the 12th cycle after acceptance; mode_q=10 throughout.
- Zero size: msize=0 -> done=1 and err=1 in the cycle after start. No w_load or if_valid ever asserted.
- Max sizes: ksize=nsize=msize=31 -> FLUSH lasts 61 cycles; done arrives 31+31+61+1=124 cycles after acceptance.
- Busy start: pulse start with different mode mid-LOAD_W -> mode_q and timing unchanged. Next start in the cycle after DONE is accepted.
- Perf (macro on): two back-to-back ops ksize=1, nsize=1, msize=1 -> busy_cycles=8. perf_clr -> 0 next cycle.
